spi_slave_rx_tx: RTL and testbench

//  SPI slave endpoint downstream of the SPI master: consumes sck/cs/mosi, returns miso.

---
 rtl/spi_slave_rx_tx_pkg.sv | 18 +
 rtl/spi_pin_sync.sv | 39 +++
 rtl/spi_slave_rx_tx.sv | 184 ++++++++++++++++++
 tb/tb_spi_slave_rx_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_rx_tx_pkg.sv
// Shared definitions for the SPI slave (and the matching master).
// Contents:
//   DEFAULT_DATA_W       default word width
//   DEFAULT_SYNC_STAGES  default synchroniser depth
//   state_t              2-bit word-sequencing FSM states
package spi_slave_rx_tx_pkg;

  localparam int DEFAULT_DATA_W      = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with single-cycle
// rise/fall pulses derived from the synchronised level.
// Ports:
//   clk, rst_n  system clock, synchronous active-low reset
//   pin         asynchronous input pin
//   sync        synchronised level (STAGES flops of delay)
//   rise, fall  1-cycle pulses on synchronised 0->1 / 1->0 transitions
// Reset loads every stage (and the edge-detect history) with RST_VAL so that
// no spurious edge appears when reset is released with the pin idle.
module spi_pin_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], pin};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI slave endpoint, fully oversampled on clk (no logic clocked by sck).
// Receives one DATA_W-bit word per slot on mosi (sampled on sck rise) and
// returns a buffered tx word on miso (updated on sck fall). Words may run
// back to back while cs stays low.
// Ports:
//   clk, rst_n          system clock, synchronous active-low reset
//   sck, cs, mosi       SPI pins from the master (asynchronous, cs active-low)
//   miso                slave-out data
//   tx_data, tx_valid   word for the next slot; accepted when tx_ready=1
//   tx_ready            tx holding register empty
//   rx_data, rx_valid   last complete word; rx_valid pulses when it updates
//   frame_err           1-cycle pulse: cs deasserted in the middle of a word
//   busy                a word slot is in progress
// Configuration macro:
//   SPI_SLAVE_LSB_FIRST_EN  defined: LSB first on both mosi and miso;
//                           undefined: MSB first.
module spi_slave_rx_tx
  import spi_slave_rx_tx_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  // Pin synchronisers; idle levels are cs=1, sck=1, mosi=0.
  logic sck_level_unused, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .pin(sck),
    .sync(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .pin(cs),
    .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .pin(mosi),
    .sync(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] hold_q, tx_shift_q, rx_shift_q, rx_data_q;
  logic              hold_full_q, miso_q, rx_valid_q, frame_err_q;

  logic do_load, do_rx, do_tx, do_done, do_err;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    do_load = 1'b0;
    do_rx   = 1'b0;
    do_tx   = 1'b0;
    do_done = 1'b0;
    do_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) state_d = LOAD;
      end
      LOAD: begin
        do_load = 1'b1;
        state_d = cs_rise ? IDLE : SHIFT;
      end
      SHIFT: begin
        // cs edge wins over any sck edge landing in the same cycle.
        if (cs_rise) begin
          // Count 0 means no bit of this slot has moved yet (e.g. cs
          // released right after a completed word), so it is not an error.
          do_err  = (bit_cnt_q != '0);
          state_d = IDLE;
        end else if (sck_rise) begin
          do_rx = 1'b1;
          if (bit_cnt_q == LAST_CNT) state_d = DONE;
        end else if (sck_fall && bit_cnt_q != '0) begin
          // A fall before the first rise is the leading edge of the slot;
          // the first bit is already on miso from LOAD.
          do_tx = 1'b1;
        end
      end
      DONE: begin
        do_done = 1'b1;
        state_d = cs_s ? IDLE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit-order dependent shift paths.
  logic [DATA_W-1:0] load_word, tx_shifted, rx_shifted;
  logic              load_bit, next_bit;

  always_comb begin
    load_word = hold_full_q ? hold_q : '0;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    load_bit   = load_word[0];
    tx_shifted = {1'b0, tx_shift_q[DATA_W-1:1]};
    next_bit   = tx_shifted[0];
    rx_shifted = {mosi_s, rx_shift_q[DATA_W-1:1]};
`else
    load_bit   = load_word[DATA_W-1];
    tx_shifted = {tx_shift_q[DATA_W-2:0], 1'b0};
    next_bit   = tx_shifted[DATA_W-1];
    rx_shifted = {rx_shift_q[DATA_W-2:0], mosi_s};
`endif
  end

  // Datapath.
  // NOTE: all state uses non-blocking assignments so each flop samples the
  // pre-edge values regardless of statement order within the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= do_done;
      frame_err_q <= do_err;

      // Writes only land when empty, and LOAD only frees a full register,
      // so a write during LOAD never collides with the copy.
      if (tx_valid && !hold_full_q) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end
      if (do_load) begin
        tx_shift_q <= load_word;
        miso_q     <= load_bit;
        bit_cnt_q  <= '0;
        if (hold_full_q) hold_full_q <= 1'b0;
      end
      if (do_rx) begin
        rx_shift_q <= rx_shifted;
        bit_cnt_q  <= bit_cnt_q + 1'b1;
      end
      if (do_tx) begin
        tx_shift_q <= tx_shifted;
        miso_q     <= next_bit;
      end
      if (do_done) rx_data_q <= rx_shift_q;
      if (state_q == IDLE) miso_q <= 1'b0;
    end
  end

  assign miso      = miso_q;
  assign tx_ready  = ~hold_full_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Self-checking bench for spi_slave_rx_tx: the bench acts as a mode-3 SPI
// master (sck idles high, data launched on fall, sampled on rise), using the
// same bit order as the DUT build.
module tb_spi_slave_rx_tx;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;

  logic              clk, rst_n, sck, cs, mosi, miso;
  logic [DATA_W-1:0] tx_data, rx_data;
  logic              tx_valid, tx_ready, rx_valid, frame_err, busy;

  spi_slave_rx_tx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Cycle counter and output monitors (sampled on the inactive edge).
  int cyc = 0, rx_cnt = 0, ferr_cnt = 0, rx_cyc = 0;
  int miso_high_cnt = 0, tx_ready_low_cnt = 0, last_rise_cyc = 0;
  logic [DATA_W-1:0] last_rx = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_cnt  <= rx_cnt + 1;
      last_rx <= rx_data;
      rx_cyc  <= cyc;
    end
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (miso === 1'b1) miso_high_cnt <= miso_high_cnt + 1;
    if (tx_ready !== 1'b1) tx_ready_low_cnt <= tx_ready_low_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int bit_idx(input int i);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return i;
`else
    return DATA_W - 1 - i;
`endif
  endfunction

  // Master shifts nbits of w out on mosi and collects miso into rd.
  task automatic spi_bits(input logic [DATA_W-1:0] w, input int nbits,
                          output logic [DATA_W-1:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      sck  = 1'b0;
      mosi = w[bit_idx(i)];
      tick(HALF);
      rd[bit_idx(i)] = miso;
      sck           = 1'b1;
      last_rise_cyc = cyc;
      tick(HALF);
    end
  endtask

  task automatic load_tx(input logic [DATA_W-1:0] b);
    int waited = 0;
    while (tx_ready !== 1'b1 && waited < 64) begin
      tick(1);
      waited++;
    end
    check("tx_ready_before_load", 32'(tx_ready), 32'(1));
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  typedef struct {
    logic [DATA_W-1:0] mosi_w;
    logic [DATA_W-1:0] tx_w;
    logic              tx_en;
    logic              new_frame;
    logic [DATA_W-1:0] exp_rx;
    logic [DATA_W-1:0] exp_miso;
  } vec_t;

  localparam int NVEC = 4;
  vec_t vecs[NVEC];

  logic [DATA_W-1:0] rd;
  int rx0, fe0, trl0, mh0;
  logic next_b2b;

  initial begin
    vecs[0] = '{mosi_w: 8'hA5, tx_w: 8'h3C, tx_en: 1'b1, new_frame: 1'b1, exp_rx: 8'hA5, exp_miso: 8'h3C};
    vecs[1] = '{mosi_w: 8'h01, tx_w: 8'h80, tx_en: 1'b1, new_frame: 1'b1, exp_rx: 8'h01, exp_miso: 8'h80};
    vecs[2] = '{mosi_w: 8'hFF, tx_w: 8'h7E, tx_en: 1'b1, new_frame: 1'b0, exp_rx: 8'hFF, exp_miso: 8'h7E};
    vecs[3] = '{mosi_w: 8'h96, tx_w: 8'h00, tx_en: 1'b0, new_frame: 1'b1, exp_rx: 8'h96, exp_miso: 8'h00};

    // Reset with cs idle.
    rst_n = 1'b0; sck = 1'b1; cs = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    tick(4);
    rst_n = 1'b1;
    tick(1);
    check("reset_miso",      32'(miso),      32'(0));
    check("reset_tx_ready",  32'(tx_ready),  32'(1));
    check("reset_rx_data",   32'(rx_data),   32'(0));
    check("reset_rx_valid",  32'(rx_valid),  32'(0));
    check("reset_frame_err", 32'(frame_err), 32'(0));
    check("reset_busy",      32'(busy),      32'(0));
    mh0 = miso_high_cnt;
    tick(20);
    check("idle_miso_low_20clk", 32'(miso_high_cnt - mh0), 32'(0));
    check("idle_tx_ready",       32'(tx_ready),            32'(1));

    // Table-driven words: single, back-to-back pair, empty holding reg.
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].new_frame) begin
        if (vecs[i].tx_en) load_tx(vecs[i].tx_w);
        cs = 1'b0;
        tick(HALF);
      end
      rx0  = rx_cnt;
      fe0  = ferr_cnt;
      trl0 = tx_ready_low_cnt;
      next_b2b = (i + 1 < NVEC) ? !vecs[i+1].new_frame : 1'b0;
      fork
        spi_bits(vecs[i].mosi_w, DATA_W, rd);
        if (next_b2b && vecs[(i+1) % NVEC].tx_en) load_tx(vecs[(i+1) % NVEC].tx_w);
      join
      check($sformatf("v%0d_miso_word", i),  32'(rd),              32'(vecs[i].exp_miso));
      check($sformatf("v%0d_rx_pulses", i),  32'(rx_cnt - rx0),    32'(1));
      check($sformatf("v%0d_rx_capture", i), 32'(last_rx),         32'(vecs[i].exp_rx));
      check($sformatf("v%0d_rx_data", i),    32'(rx_data),         32'(vecs[i].exp_rx));
      check($sformatf("v%0d_no_ferr", i),    32'(ferr_cnt - fe0),  32'(0));
      check($sformatf("v%0d_rx_latency", i), 32'(rx_cyc - last_rise_cyc), 32'(SYNC_STAGES + 2));
      if (!vecs[i].tx_en && vecs[i].new_frame)
        check($sformatf("v%0d_tx_ready_held", i), 32'(tx_ready_low_cnt - trl0), 32'(0));
      if (!next_b2b) begin
        cs = 1'b1;
        tick(12);
        check($sformatf("v%0d_idle_busy", i), 32'(busy), 32'(0));
      end
    end

    // cs raised after 5 bits; a tx word loaded mid-slot must survive the abort.
    rx0 = rx_cnt;
    fe0 = ferr_cnt;
    cs  = 1'b0;
    tick(HALF);
    load_tx(8'h11);
    spi_bits(8'h3A, 5, rd);
    check("abort_busy_mid_word", 32'(busy), 32'(1));
    cs = 1'b1;
    tick(12);
    check("abort_ferr_pulse",   32'(ferr_cnt - fe0), 32'(1));
    check("abort_no_rx_valid",  32'(rx_cnt - rx0),   32'(0));
    check("abort_rx_data_kept", 32'(rx_data),        32'(vecs[NVEC-1].exp_rx));
    check("abort_busy_clear",   32'(busy),           32'(0));
    cs = 1'b0;
    tick(HALF);
    spi_bits(8'h5A, DATA_W, rd);
    cs = 1'b1;
    tick(12);
    check("after_abort_rx_data", 32'(rx_data),        32'(8'h5A));
    check("after_abort_rx_cnt",  32'(rx_cnt - rx0),   32'(1));
    check("after_abort_miso",    32'(rd),             32'(8'h11));
    check("after_abort_ferr",    32'(ferr_cnt - fe0), 32'(1));

    // Synchronous reset in the middle of a word, then a clean word.
    cs = 1'b0;
    tick(HALF);
    spi_bits(8'hF0, 4, rd);
    rx0 = rx_cnt;
    fe0 = ferr_cnt;
    rst_n = 1'b0;
    tick(3);
    check("midrst_busy",     32'(busy),     32'(0));
    check("midrst_tx_ready", 32'(tx_ready), 32'(1));
    check("midrst_rx_data",  32'(rx_data),  32'(0));
    check("midrst_miso",     32'(miso),     32'(0));
    cs = 1'b1; sck = 1'b1; mosi = 1'b0;
    rst_n = 1'b1;
    tick(12);
    check("midrst_no_rx_valid", 32'(rx_cnt - rx0),   32'(0));
    check("midrst_no_ferr",     32'(ferr_cnt - fe0), 32'(0));
    load_tx(8'h69);
    cs = 1'b0;
    tick(HALF);
    spi_bits(8'hC3, DATA_W, rd);
    cs = 1'b1;
    tick(12);
    check("postrst_rx_data", 32'(rx_data),        32'(8'hC3));
    check("postrst_rx_cnt",  32'(rx_cnt - rx0),   32'(1));
    check("postrst_miso",    32'(rd),             32'(8'h69));
    check("postrst_no_ferr", 32'(ferr_cnt - fe0), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
